// File: rtl/ctrl_api_pkg.sv
// ctrl_api_pkg: LAN control-message field layout, message encodings, AXI responses
// and the converter state enum shared by the network/AXI-Lite control path.
package ctrl_api_pkg;
   localparam int TYPE_OFF  = 0;
   localparam int TYPE_W    = 4;
   localparam int DATA_OFF  = 4;
   localparam int DATA_W    = 32;
   localparam int ADDR_OFF  = 36;
   localparam int ADDR_W    = 56;
   localparam int WSTRB_OFF = 92;
   localparam int WSTRB_W   = 4;
   localparam logic [3:0] MSG_READ  = 4'h1;
   localparam logic [3:0] MSG_WRITE = 4'h2;
   localparam logic [3:0] MSG_BRESP = 4'h3;
   localparam logic [3:0] MSG_RDATA = 4'h4;
   localparam logic [3:0] MSG_BUSY  = 4'h5;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, SEND} state_t;
endpackage

// File: rtl/network_to_axilite_converter_if.sv
// network_to_axilite_converter_if: request/response AXI-Stream plus AXI-Lite master bundle;
// master is the converter's view, slave is the surrounding environment's view.
interface network_to_axilite_converter_if #(
   parameter int AXIS_DATA_WIDTH  = 128,
   parameter int AXIS_KEEP_WIDTH  = 16,
   parameter int AXIS_TDEST_WIDTH = 8,
   parameter int AXIS_TUSER_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH   = 56,
   parameter int AXI_DATA_WIDTH   = 32
);
   logic                          from_splitter_tvalid;
   logic                          from_splitter_tready;
   logic [AXIS_DATA_WIDTH-1:0]    from_splitter_tdata;
   logic [AXIS_KEEP_WIDTH-1:0]    from_splitter_tkeep;
   logic [AXIS_TDEST_WIDTH-1:0]   from_splitter_tid;
   logic [AXIS_TDEST_WIDTH-1:0]   from_splitter_tdest;
   logic [AXIS_TUSER_WIDTH-1:0]   from_splitter_tuser;
   logic                          from_splitter_tlast;
   logic                          to_network_bridge_tvalid;
   logic                          to_network_bridge_tready;
   logic [AXIS_DATA_WIDTH-1:0]    to_network_bridge_tdata;
   logic [AXIS_KEEP_WIDTH-1:0]    to_network_bridge_tkeep;
   logic [AXIS_TDEST_WIDTH-1:0]   to_network_bridge_tid;
   logic [AXIS_TDEST_WIDTH-1:0]   to_network_bridge_tdest;
   logic [AXIS_TUSER_WIDTH-1:0]   to_network_bridge_tuser;
   logic                          to_network_bridge_tlast;
   logic                          m_axi_awvalid;
   logic                          m_axi_awready;
   logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr;
   logic [2:0]                    m_axi_awprot;
   logic                          m_axi_wvalid;
   logic                          m_axi_wready;
   logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata;
   logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb;
   logic                          m_axi_bvalid;
   logic                          m_axi_bready;
   logic [1:0]                    m_axi_bresp;
   logic                          m_axi_arvalid;
   logic                          m_axi_arready;
   logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr;
   logic [2:0]                    m_axi_arprot;
   logic                          m_axi_rvalid;
   logic                          m_axi_rready;
   logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata;
   logic [1:0]                    m_axi_rresp;
   modport master (
      input  from_splitter_tvalid, from_splitter_tdata, from_splitter_tkeep, from_splitter_tid,
             from_splitter_tdest, from_splitter_tuser, from_splitter_tlast, to_network_bridge_tready,
             m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp, m_axi_arready,
             m_axi_rvalid, m_axi_rdata, m_axi_rresp,
      output from_splitter_tready, to_network_bridge_tvalid, to_network_bridge_tdata,
             to_network_bridge_tkeep, to_network_bridge_tid, to_network_bridge_tdest,
             to_network_bridge_tuser, to_network_bridge_tlast, m_axi_awvalid, m_axi_awaddr,
             m_axi_awprot, m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_bready,
             m_axi_arvalid, m_axi_araddr, m_axi_arprot, m_axi_rready
   );
   modport slave (
      output from_splitter_tvalid, from_splitter_tdata, from_splitter_tkeep, from_splitter_tid,
             from_splitter_tdest, from_splitter_tuser, from_splitter_tlast, to_network_bridge_tready,
             m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp, m_axi_arready,
             m_axi_rvalid, m_axi_rdata, m_axi_rresp,
      input  from_splitter_tready, to_network_bridge_tvalid, to_network_bridge_tdata,
             to_network_bridge_tkeep, to_network_bridge_tid, to_network_bridge_tdest,
             to_network_bridge_tuser, to_network_bridge_tlast, m_axi_awvalid, m_axi_awaddr,
             m_axi_awprot, m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_bready,
             m_axi_arvalid, m_axi_araddr, m_axi_arprot, m_axi_rready
   );
endinterface

// File: rtl/network_to_axilite_converter.sv
// network_to_axilite_converter: runs each MSG_WRITE/MSG_READ request as one AXI-Lite
// transaction and answers the requester with MSG_BRESP/MSG_RDATA; one request in flight.
module network_to_axilite_converter
   import ctrl_api_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH  = 128,
   parameter int AXIS_KEEP_WIDTH  = 16,
   parameter int AXIS_TDEST_WIDTH = 8,
   parameter int AXIS_TUSER_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH   = 56,
   parameter int AXI_DATA_WIDTH   = 32
) (
   input logic i_clk,
   input logic i_ap_rst,
   network_to_axilite_converter_if.master io_bus
);
   state_t                        r_state;
   state_t                        w_next;
   logic [AXIS_TDEST_WIDTH-1:0]   r_tid;
   logic [AXIS_TDEST_WIDTH-1:0]   r_tdest;
   logic [AXIS_TUSER_WIDTH-1:0]   r_tuser;
   logic [AXIS_KEEP_WIDTH-1:0]    r_tkeep;
   logic [AXI_ADDR_WIDTH-1:0]     r_addr;
   logic [AXI_DATA_WIDTH-1:0]     r_data;
   logic [AXI_DATA_WIDTH/8-1:0]   r_wstrb;
   logic [AXI_DATA_WIDTH-1:0]     r_rdata;
   logic [1:0]                    r_resp;
   logic                          r_rd;
   logic                          r_aw_done;
   logic                          r_w_done;
   logic                          w_accept;
   logic                          w_aw_hs;
   logic                          w_w_hs;
   logic [3:0]                    w_type;
   logic [AXIS_DATA_WIDTH-1:0]    w_resp;
   logic                          w_unused;
   assign w_type   = io_bus.from_splitter_tdata[TYPE_OFF +: TYPE_W];
   assign w_accept = io_bus.from_splitter_tvalid && r_state == IDLE && !i_ap_rst;
   assign w_aw_hs  = r_state == WR_REQ && !r_aw_done && io_bus.m_axi_awready;
   assign w_w_hs   = r_state == WR_REQ && !r_w_done && io_bus.m_axi_wready;
   assign w_unused = &{1'b0, io_bus.from_splitter_tlast,
                       io_bus.from_splitter_tdata[AXIS_DATA_WIDTH-1:WSTRB_OFF+WSTRB_W]};
   always_ff @(posedge i_clk) begin
      if (i_ap_rst) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = w_type == MSG_WRITE ? WR_REQ : w_type == MSG_READ ? RD_REQ : IDLE;
         WR_REQ:  if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = WR_RESP;
         WR_RESP: if (io_bus.m_axi_bvalid) w_next = SEND;
         RD_REQ:  if (io_bus.m_axi_arready) w_next = RD_RESP;
         RD_RESP: if (io_bus.m_axi_rvalid) w_next = SEND;
         SEND:    if (io_bus.to_network_bridge_tready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_ap_rst) begin
         r_tid     <= '0;
         r_tdest   <= '0;
         r_tuser   <= '0;
         r_tkeep   <= '0;
         r_addr    <= '0;
         r_data    <= '0;
         r_wstrb   <= '0;
         r_rdata   <= '0;
         r_resp    <= '0;
         r_rd      <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_tid     <= io_bus.from_splitter_tid;
            r_tdest   <= io_bus.from_splitter_tdest;
            r_tuser   <= io_bus.from_splitter_tuser;
            r_tkeep   <= io_bus.from_splitter_tkeep;
            r_addr    <= io_bus.from_splitter_tdata[ADDR_OFF +: AXI_ADDR_WIDTH];
            r_data    <= io_bus.from_splitter_tdata[DATA_OFF +: AXI_DATA_WIDTH];
            r_wstrb   <= io_bus.from_splitter_tdata[WSTRB_OFF +: AXI_DATA_WIDTH/8];
            r_rd      <= w_type == MSG_READ;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end
         if (w_aw_hs) r_aw_done <= 1'b1;
         if (w_w_hs) r_w_done <= 1'b1;
         if (r_state == WR_RESP && io_bus.m_axi_bvalid) r_resp <= io_bus.m_axi_bresp;
         if (r_state == RD_RESP && io_bus.m_axi_rvalid) begin
            r_resp  <= io_bus.m_axi_rresp;
            r_rdata <= io_bus.m_axi_rdata;
         end
      end
   end
   // Response message: addr field and unused bits stay zero.
   always_comb begin
      w_resp = '0;
      w_resp[TYPE_OFF +: TYPE_W]   = r_rd ? MSG_RDATA : MSG_BRESP;
      w_resp[DATA_OFF +: DATA_W]   = r_rd ? r_rdata : '0;
      w_resp[WSTRB_OFF +: WSTRB_W] = {2'b00, r_resp};
   end
   always_comb begin
      io_bus.from_splitter_tready     = r_state == IDLE && !i_ap_rst;
      io_bus.m_axi_awvalid            = r_state == WR_REQ && !r_aw_done;
      io_bus.m_axi_awaddr             = r_addr;
      io_bus.m_axi_awprot             = 3'b000;
      io_bus.m_axi_wvalid             = r_state == WR_REQ && !r_w_done;
      io_bus.m_axi_wdata              = r_data;
      io_bus.m_axi_wstrb              = r_wstrb;
      io_bus.m_axi_bready             = r_state == WR_RESP;
      io_bus.m_axi_arvalid            = r_state == RD_REQ;
      io_bus.m_axi_araddr             = r_addr;
      io_bus.m_axi_arprot             = 3'b000;
      io_bus.m_axi_rready             = r_state == RD_RESP;
      io_bus.to_network_bridge_tvalid = r_state == SEND;
      io_bus.to_network_bridge_tdata  = r_state == SEND ? w_resp : '0;
      io_bus.to_network_bridge_tid    = r_state == SEND ? r_tdest : '0;
      io_bus.to_network_bridge_tdest  = r_state == SEND ? r_tid : '0;
      io_bus.to_network_bridge_tuser  = r_state == SEND ? r_tuser : '0;
      io_bus.to_network_bridge_tkeep  = r_state == SEND ? r_tkeep : '0;
      io_bus.to_network_bridge_tlast  = r_state == SEND;
   end
endmodule
